// File: rtl/div_unit_pkg.sv
// Shared CPU arithmetic constants: divider state encoding, widths and iteration
// count, kept next to the multiplier constants used by the sibling mul unit.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = DIV_WIDTH;
   localparam int DIV_CNT_W = 5;

   localparam int MUL_WIDTH   = 32;
   localparam int MUL_LATENCY = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RUN   = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract the
// divisor magnitude, keep or restore, and shift the new quotient bit in.
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quot_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quot_out
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      rem_sh = {rem_in[WIDTH-1:0], quot_in[WIDTH-1]};
      diff   = rem_sh - {1'b0, divisor};
      // A set top bit would mean the shifted remainder already exceeds any divisor.
      fits   = rem_in[WIDTH] | (rem_sh >= {1'b0, divisor});
      if (fits) begin
         rem_out  = diff;
         quot_out = {quot_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out  = rem_sh;
         quot_out = {quot_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency signed restoring divider: quotient truncates toward zero and
// the remainder takes the sign of the dividend; a zero divisor is flagged.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] cHI,
   output logic [WIDTH-1:0] cLOW
);

   localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(WIDTH - 1);

   div_state_e           state;
   div_state_e           state_nxt;
   logic [DIV_CNT_W-1:0] cnt;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     dvs;
   logic [WIDTH-1:0]     quot;
   logic [WIDTH-1:0]     quot_step;
   logic [WIDTH:0]       rem;
   logic [WIDTH:0]       rem_step;
   logic [WIDTH-1:0]     q_fix;
   logic [WIDTH-1:0]     r_fix;
   logic                 neg_a;
   logic                 neg_b;
   logic                 zero_div;
   logic                 load_ops;
   logic                 setup_en;
   logic                 run_en;
   logic                 fix_en;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SETUP;
         S_SETUP: state_nxt = S_RUN;
         S_RUN:   if (cnt == '0) state_nxt = S_FIXUP;
         S_FIXUP: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      load_ops = (state == S_IDLE) && start;
      setup_en = (state == S_SETUP);
      run_en   = (state == S_RUN);
      fix_en   = (state == S_FIXUP);
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quot_in (quot),
      .divisor (dvs),
      .rem_out (rem_step),
      .quot_out(quot_step)
   );

   // Zero divisor bypasses the sign fixup and reports the dividend unchanged.
   always_comb begin
      q_fix = (neg_a ^ neg_b) ? -quot : quot;
      r_fix = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      if (zero_div) begin
         q_fix = '1;
         r_fix = a_q;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         a_q      <= '0;
         b_q      <= '0;
         dvs      <= '0;
         quot     <= '0;
         rem      <= '0;
         cnt      <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         zero_div <= 1'b0;
         cHI      <= '0;
         cLOW     <= '0;
         div_zero <= 1'b0;
      end else begin
         if (load_ops) begin
            a_q <= a;
            b_q <= b;
         end
         if (setup_en) begin
            neg_a    <= a_q[WIDTH-1];
            neg_b    <= b_q[WIDTH-1];
            zero_div <= (b_q == '0);
            quot     <= a_q[WIDTH-1] ? -a_q : a_q;
            dvs      <= b_q[WIDTH-1] ? -b_q : b_q;
            rem      <= '0;
            cnt      <= CNT_LOAD;
         end
         if (run_en) begin
            rem  <= rem_step;
            quot <= quot_step;
            if (cnt != '0) cnt <= cnt - DIV_CNT_W'(1);
         end
         if (fix_en) begin
            cHI      <= r_fix;
            cLOW     <= q_fix;
            div_zero <= zero_div;
         end
      end
   end

endmodule
